// File: rtl/hls_kernel_arbiter.sv
// hls_kernel_arbiter: round-robin front end that shares one start/done HLS
// kernel among NREQ requesters. It latches the winner's operands, pulses the
// kernel start, waits for done under a watchdog, then returns the results
// with a one-cycle acknowledge. A watchdog timeout parks the block in an
// error state, with the kernel held in abort, until software clears it.
module hls_kernel_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [NREQ-1:0]   Req,
   input  logic [NREQ*DW-1:0] ReqA,
   input  logic [NREQ*DW-1:0] ReqB,
   input  logic [NREQ*DW-1:0] ReqC,
   output logic [NREQ-1:0]   Ack,
   output logic [2:0]        RespId,
   output logic [DW-1:0]     RespZ,
   output logic [DW-1:0]     RespX,
   output logic [DW-1:0]     KA,
   output logic [DW-1:0]     KB,
   output logic [DW-1:0]     KC,
   output logic              KStart,
   input  logic              KDone,
   input  logic [DW-1:0]     KZ,
   input  logic [DW-1:0]     KX,
   output logic              KAbort,
   input  logic              ErrorRst,
   output logic              Error
);

   // Watchdog counter is just wide enough to hold TIMEOUT.
   localparam int            CW  = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

   state_t          state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [2:0]      gid_q, gid_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [2:0]      resp_id_q, resp_id_d;
   logic [DW-1:0]   resp_z_q, resp_z_d;
   logic [DW-1:0]   resp_x_q, resp_x_d;
   logic [DW-1:0]   ka_q, ka_d;
   logic [DW-1:0]   kb_q, kb_d;
   logic [DW-1:0]   kc_q, kc_d;
   logic            kstart_q, kstart_d;
   logic            kabort_q, kabort_d;
   logic            error_q, error_d;

   logic [2*NREQ-1:0] req2;
   logic [NREQ-1:0]   rot;
   logic [2:0]        off;
   logic [3:0]        sum;
   logic              gnt_vld;
   logic [2:0]        gnt_idx;
   logic [DW-1:0]     sel_a, sel_b, sel_c;
   logic [2:0]        next_ptr;

   // Rotate requests so Ptr sits at bit 0, take the lowest set bit, then
   // rotate the offset back into a requester index.
   always_comb begin
      req2    = {Req, Req} >> ptr_q;
      rot     = req2[NREQ-1:0];
      gnt_vld = 1'b0;
      off     = 3'd0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            gnt_vld = 1'b1;
            off     = 3'(j);
         end
      end
      sum     = {1'b0, ptr_q} + {1'b0, off};
      gnt_idx = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      sel_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == 3'(i)) begin
            sel_a = ReqA[i*DW +: DW];
            sel_b = ReqB[i*DW +: DW];
            sel_c = ReqC[i*DW +: DW];
         end
      end
   end

   // Next-state and registered-output logic for the sequencer.
   always_comb begin
      next_ptr  = (gid_q == 3'(NREQ - 1)) ? 3'd0 : gid_q + 3'd1;
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      cnt_d     = cnt_q;
      resp_id_d = resp_id_q;
      resp_z_d  = resp_z_q;
      resp_x_d  = resp_x_q;
      ka_d      = ka_q;
      kb_d      = kb_q;
      kc_d      = kc_q;
      unique case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               gid_d   = gnt_idx;
               ka_d    = sel_a;
               kb_d    = sel_b;
               kc_d    = sel_c;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done beats the watchdog when both land in the same cycle.
            if (KDone) begin
               resp_z_d = KZ;
               resp_x_d = KX;
               state_d  = S_RESP;
            end else if (cnt_q == TMO) begin
               // Advance past the faulty requester so it cannot hog the kernel.
               ptr_d   = next_ptr;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            ptr_d   = next_ptr;
            state_d = S_IDLE;
         end
         S_ERR: begin
            if (ErrorRst) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pulse/level outputs are decoded from the next state so they appear
      // registered in the same cycle the state is entered.
      kstart_d = (state_d == S_ISSUE);
      error_d  = (state_d == S_ERR);
      kabort_d = (state_d == S_ERR);
      ack_d    = '0;
      if (state_d == S_RESP) begin
         resp_id_d = gid_q;
         for (int i = 0; i < NREQ; i++) ack_d[i] = (gid_q == 3'(i));
      end
   end

   // State and output registers, all cleared by the asynchronous reset.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         gid_q     <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         resp_id_q <= '0;
         resp_z_q  <= '0;
         resp_x_q  <= '0;
         ka_q      <= '0;
         kb_q      <= '0;
         kc_q      <= '0;
         kstart_q  <= 1'b0;
         kabort_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gid_q     <= gid_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         resp_id_q <= resp_id_d;
         resp_z_q  <= resp_z_d;
         resp_x_q  <= resp_x_d;
         ka_q      <= ka_d;
         kb_q      <= kb_d;
         kc_q      <= kc_d;
         kstart_q  <= kstart_d;
         kabort_q  <= kabort_d;
         error_q   <= error_d;
      end
   end

   assign Ack    = ack_q;
   assign RespId = resp_id_q;
   assign RespZ  = resp_z_q;
   assign RespX  = resp_x_q;
   assign KA     = ka_q;
   assign KB     = kb_q;
   assign KC     = kc_q;
   assign KStart = kstart_q;
   assign KAbort = kabort_q;
   assign Error  = error_q;

endmodule

// File: tb/tb_hls_kernel_arbiter.sv
// Directed bench for hls_kernel_arbiter: fairness, single request, spurious
// done, watchdog timeout and clear, done/timeout race, async reset mid-WAIT.
module tb_hls_kernel_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;

   logic              Clk = 1'b0;
   logic              Rst;
   logic [NREQ-1:0]   Req;
   logic [NREQ*DW-1:0] ReqA, ReqB, ReqC;
   logic [NREQ-1:0]   Ack;
   logic [2:0]        RespId;
   logic [DW-1:0]     RespZ, RespX, KA, KB, KC, KZ, KX;
   logic              KStart, KDone, KAbort, ErrorRst, Error;

   int n_cmp = 0;
   int n_bad = 0;

   hls_kernel_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(15)) dut (
      .Clk(Clk), .Rst(Rst), .Req(Req), .ReqA(ReqA), .ReqB(ReqB), .ReqC(ReqC),
      .Ack(Ack), .RespId(RespId), .RespZ(RespZ), .RespX(RespX),
      .KA(KA), .KB(KB), .KC(KC), .KStart(KStart), .KDone(KDone),
      .KZ(KZ), .KX(KX), .KAbort(KAbort), .ErrorRst(ErrorRst), .Error(Error)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      Rst = 1'b0; Req = '0; KDone = 1'b0; KZ = '0; KX = '0; ErrorRst = 1'b0;
      ReqA = {32'hA3, 32'hA2, 32'hA1, 32'd5};
      ReqB = {32'hB3, 32'hB2, 32'hB1, 32'd7};
      ReqC = {32'hC3, 32'hC2, 32'hC1, 32'd3};
      ticks(3);
      chk("rst_ack", 32'(Ack), 0);
      chk("rst_kstart", 32'(KStart), 0);
      chk("rst_error", 32'(Error), 0);
      chk("rst_kabort", 32'(KAbort), 0);
      chk("rst_ka", KA, 0);
      chk("rst_respz", RespZ, 0);
      Rst = 1'b1;
      tick();

      // Fairness: all requesting, kernel done on first WAIT cycle.
      Req = 4'b1111; KDone = 1'b1; KZ = 32'h11; KX = 32'h22;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("fair_kstart", 32'(KStart), 1);
         tick();
         chk("fair_wait_ack", 32'(Ack), 0);
         tick();
         chk("fair_ack", 32'(Ack), 32'(1 << (k % 4)));
         chk("fair_respid", 32'(RespId), 32'(k % 4));
         if (k == 4) begin Req = '0; KDone = 1'b0; end
         tick();
         chk("fair_idle_ack", 32'(Ack), 0);
      end
      chk("fair_respz", RespZ, 32'h11);

      // Single request from requester 0; Req dropped after grant.
      Req = 4'b0001;
      tick();
      chk("s_kstart", 32'(KStart), 1);
      chk("s_ka", KA, 5);
      chk("s_kb", KB, 7);
      chk("s_kc", KC, 3);
      Req = '0;
      tick();
      chk("s_kstart_off", 32'(KStart), 0);
      ticks(2);
      chk("s_no_ack", 32'(Ack), 0);
      KDone = 1'b1; KZ = 32'd12; KX = 32'd24;
      tick();
      KDone = 1'b0;
      chk("s_ack", 32'(Ack), 32'b0001);
      chk("s_respz", RespZ, 12);
      chk("s_respx", RespX, 24);
      chk("s_respid", 32'(RespId), 0);
      tick();
      chk("s_ack_off", 32'(Ack), 0);

      // Spurious KDone in IDLE must not change anything.
      KDone = 1'b1; KZ = 32'd99; KX = 32'd98;
      ticks(2);
      KDone = 1'b0;
      chk("sp_kstart", 32'(KStart), 0);
      chk("sp_ack", 32'(Ack), 0);
      chk("sp_respz", RespZ, 12);

      // Timeout: Ptr=1, only requester 2 asks.
      Req = 4'b0100;
      tick();
      chk("to_ka", KA, 32'hA2);
      Req = 4'b1100;
      ticks(16);
      chk("to_err_pre", 32'(Error), 0);
      tick();
      chk("to_error", 32'(Error), 1);
      chk("to_kabort", 32'(KAbort), 1);
      chk("to_no_ack", 32'(Ack), 0);
      ticks(3);
      chk("to_error_hold", 32'(Error), 1);
      ErrorRst = 1'b1;
      tick();
      ErrorRst = 1'b0;
      chk("to_clr_error", 32'(Error), 0);
      chk("to_clr_kabort", 32'(KAbort), 0);
      tick();
      chk("to_next_ka", KA, 32'hA3);
      chk("to_next_kstart", 32'(KStart), 1);
      Req = '0;
      tick();
      KDone = 1'b1; KZ = 32'h33;
      tick();
      KDone = 1'b0;
      chk("to_next_ack", 32'(Ack), 32'b1000);
      chk("to_next_id", 32'(RespId), 3);
      tick();

      // Race: KDone on the cycle the counter equals TIMEOUT (Ptr=0).
      Req = 4'b0001;
      tick();
      Req = '0;
      ticks(16);
      KDone = 1'b1; KZ = 32'h44;
      tick();
      KDone = 1'b0;
      chk("race_ack", 32'(Ack), 32'b0001);
      chk("race_error", 32'(Error), 0);
      chk("race_respz", RespZ, 32'h44);
      tick();

      // Async reset in WAIT; requester 2 pending, Ptr was 1.
      Req = 4'b0100;
      ticks(3);
      #3 Rst = 1'b0;
      #1;
      chk("ar_ka", KA, 0);
      chk("ar_respz", RespZ, 0);
      chk("ar_respid", 32'(RespId), 0);
      chk("ar_kstart", 32'(KStart), 0);
      chk("ar_error", 32'(Error), 0);
      #2 Rst = 1'b1;
      tick();
      chk("ar_kstart2", 32'(KStart), 1);
      chk("ar_ka2", KA, 32'hA2);
      Req = '0;
      tick();
      KDone = 1'b1; KZ = 32'h55;
      tick();
      KDone = 1'b0;
      chk("ar_ack", 32'(Ack), 32'b0100);
      chk("ar_id", 32'(RespId), 2);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hls_kernel_arbiter.md
# hls_kernel_arbiter

Round-robin arbiter and sequencer that shares one scheduled HLS kernel (three 32-bit operands a, b, c in; two 32-bit results z, x out; start/done handshake) among NREQ requesters. It latches the granted requester's operands and pulses the kernel start. It waits for kernel completion under a watchdog, returns the results with a one-cycle acknowledge, and holds an error state on timeout until software clears it. It sits between the requesting control blocks and a single kernel instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 32: operand/result width.
- TIMEOUT, 15: maximum WAIT cycles before the watchdog fires (1..255).

- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- Req  in  NREQ  per-requester request level.
- ReqA, ReqB, ReqC  in  NREQ*DW each  operands, requester i in bits [i*DW +: DW].
- Ack  out  NREQ  one-hot, one-cycle completion pulse.
- RespId  out  3  index of the requester being acknowledged.
- RespZ, RespX  out  DW each  kernel results for the acknowledged request.
- KA, KB, KC  out  DW each  operands to the kernel.
- KStart  out  1  kernel start pulse.
- KDone  in  1  kernel completion, valid only in WAIT.
- KZ, KX  in  DW each  kernel results, valid when KDone=1.
- KAbort  out  1  holds the kernel in abort while in ERR.
- ErrorRst  in  1  clears the error state.
- Error  out  1  watchdog fired.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- Reset (Rst=0, any time, including mid-transaction):
  - State goes to IDLE and the priority pointer Ptr goes to 0.
  - All outputs go to 0: Ack, RespId, RespZ, RespX, KA, KB, KC, KStart, KAbort, Error.
  - The watchdog counter goes to 0.
- IDLE:
  - With any Req bit set, grant the first set bit scanning Ptr, Ptr+1, … (mod NREQ).
  - On the grant, register the index into Gid and latch that requester's operands into KA/KB/KC. Next state is ISSUE.
  - With no Req bit set, stay in IDLE.
- ISSUE: KStart=1 for exactly this cycle. Clear the counter. Next state is WAIT.
- WAIT:
  - If KDone=1: capture KZ/KX into RespZ/RespX and move to RESP.
  - Else if the counter equals TIMEOUT: move to ERR.
  - Else: increment the counter and stay.
  - If KDone=1 in the same cycle the counter equals TIMEOUT, KDone wins (no error).
- RESP:
  - Ack[Gid]=1 and RespId=Gid for this cycle only.
  - Ptr becomes (Gid+1) mod NREQ. Next state is IDLE.
- ERR:
  - Error=1 and KAbort=1 while in this state.
  - Ptr becomes (Gid+1) mod NREQ on entry, so a faulty requester cannot monopolise the kernel.
  - No Ack is issued for the aborted request; its Req stays pending and is re-arbitrated later.
  - ErrorRst=1 moves the block to IDLE on the next edge, with Error and KAbort cleared there.
- ErrorRst outside ERR is ignored. KDone outside WAIT is ignored.
- Operands are latched at grant, so requesters need not hold ReqA/B/C afterwards.
  - If Req drops after grant, the transaction still completes and Ack still pulses.
- KA/KB/KC hold until the next grant. RespZ/RespX/RespId hold until the next RESP.
- No arithmetic on the data. The counter is ceil(log2(TIMEOUT+1)) bits wide and never wraps.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Req high in IDLE at edge n:
  - KStart high in cycle n+1 (ISSUE).
  - First KDone sample in cycle n+2.
  - If KDone is seen in WAIT cycle w, Ack is high in cycle w+1.
- Minimum issue-to-issue spacing is 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Watchdog: with no KDone, WAIT lasts TIMEOUT+1 cycles, then Error rises on the next edge.
- Back-to-back: a Req still high in the IDLE cycle after RESP is granted immediately, subject to Ptr.

## Test plan
- Single request: Req=0001, ReqA/B/C[0]=5/7/3, KDone returned 3 cycles after KStart with KZ=12, KX=24.
  - Expect KA/KB/KC=5/7/3 and one KStart pulse.
  - Expect Ack=0001 one cycle after KDone, RespZ=12, RespX=24, RespId=0.
- Fairness: Req=1111 held, kernel always done after 1 WAIT cycle.
  - Expect Ack order 0,1,2,3,0 and exactly 4-cycle spacing between Acks.
- Timeout: TIMEOUT=15, requester 2 granted, KDone never asserted.
  - Expect Error=1 and KAbort=1 after 16 WAIT cycles, no Ack, Ptr=3.
  - ErrorRst=1 returns the block to IDLE with Error=0, and requester 3 is granted next.
- Race: KDone=1 in the same cycle the counter reaches TIMEOUT.
  - Expect Ack, Error stays 0.
- Reset mid-WAIT: drive Rst=0 asynchronously between edges.
  - All outputs are 0 immediately and state is IDLE. After release, the pending Req=0100 is granted from Ptr=0.
- Req dropped after ISSUE: Ack still pulses for that requester. Spurious KDone in IDLE has no effect.
